taint_mem_responder: RTL and testbench
======================================

Name: taint_mem_responder

Overview:
- Synthesizable data-memory responder for the taint-instrumented SoC. It sits on the core's data_mem request bus, where the testbench is only the observer.
- Serves reads and writes from a value array and a parallel taint-shadow array, propagating taint from address, strobe, write-enable and write data into the shadow.
- Detects stop and trap signal stores and runs a drain countdown before raising done, so end-of-test is decided in hardware rather than in the bench.

Parameters:
- Depth, 1<<15, memory depth in 32-bit words; power of two.
- Aw, $clog2(Depth), word-address width; derived, not overridden.
- StopAddr, 0, word address of the stop-signal store.
- TrapAddr, 8, word address of the trap-signal store.
- DrainCycles, 50, cycles from stop acceptance to done_o.
- StopOnTrap, 1, 1: a trap store behaves as a stop; 0: the trap is only counted.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid; one request per cycle, always accepted.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  Aw  word address.
- wdata_i  in  32  write data.
- strb_i  in  4  byte-enable strobe.
- req_t0_i, we_t0_i, addr_t0_i, wdata_t0_i, strb_t0_i  in  1/1/Aw/32/4  taint of each request field.
- rdata_o  out  32  read data.
- rdata_t0_o  out  32  read-data taint.
- rvalid_o  out  1  read data valid.
- stop_o  out  1  sticky: a stop was accepted.
- trap_o  out  1  sticky: a trap store was seen.
- trap_cnt_o  out  16  number of trap stores.
- stop_data_tainted_o  out  1  sticky: the accepted stop store carried tainted data.
- taddr_o  out  1  sticky: a request was made with a tainted address.
- done_o  out  1  sticky: drain complete.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - All outputs and FSM state are 0 and the counter is 0.
  - The value array and taint array are not reset; the bench preloads both.
- Write (req_i & we_i): for each byte b with strb_i[b]=1:
  - mem[addr_i][b] <= wdata_i[b];
  - tmem[addr_i][b] <= wdata_t0_i[b] | {8{|addr_t0_i | we_t0_i | strb_t0_i[b]}}.
  - Bytes with strb_i[b]=0 are unchanged. strb_i=0 writes nothing.
  - rvalid_o stays 0 for writes.
- Read (req_i & ~we_i):
  - rdata_o = mem[addr_i] and rvalid_o = 1 exactly one cycle later.
  - rdata_t0_o = tmem[addr_i] | {32{|addr_t0_i | req_t0_i}}.
  - rdata_o and rdata_t0_o hold their values when idle; rvalid_o pulses for one cycle.
- Back-to-back requests at full throughput. A read of the word written in the previous cycle returns the new data and taint.
- taddr_o sets on any req_i with |addr_t0_i.
- Signal stores are writes to StopAddr or TrapAddr with any strb. They also update memory like any other write.
- Stop FSM:
  - IDLE: a stop store, or a trap store with StopOnTrap=1, goes to DRAIN. On that transition: cnt <= DrainCycles; stop_o <= 1; stop_data_tainted_o <= |wdata_t0_i.
  - A trap store in any state sets trap_o and increments trap_cnt_o, saturating at 16'hFFFF.
  - DRAIN: cnt decrements each cycle. On the cycle cnt==0 is observed, go to DONE. Total latency from the stop write to done_o = DrainCycles+1 cycles. Further stop stores are ignored (no re-arm); memory still updates.
  - DONE: done_o = 1. Requests are still served. Only reset exits.
  - DrainCycles=0: done_o is asserted on the cycle after the stop write.
- Reset asserted mid-DRAIN returns to IDLE immediately and clears all sticky flags.
- Write-data taint on a stop store does not affect the FSM, only stop_data_tainted_o.

Optional Feature:
- Macro: TAINT_MEM_RESPONDER_INJECT_EN.
- Defined: adds inputs inj_base_i [Aw] and inj_len_i [Aw]. Any read with inj_base_i <= addr_i < inj_base_i+inj_len_i, computed in Aw+1 bits with no wrap, forces rdata_t0_o = 32'hFFFFFFFF. Stored taint is unchanged. inj_len_i=0 disables injection.
- Undefined: the ports are absent; read taint comes only from tmem and the request taint.

Test Plan:
- Write 32'hDEADBEEF to word 5 with strb=4'b0101, taints 0, after preload 0 -> read word 5: rdata=32'h00AD00EF, rdata_t0=0, rvalid one cycle after req.
- Write word 7 with wdata_t0=32'h000000FF and strb=4'hF, then read with addr_t0=1 -> rdata_t0=32'hFFFFFFFF, taddr_o=1.
- Stop store to addr 0 with wdata_t0=1, DrainCycles=50 -> stop_o=1 the next cycle, stop_data_tainted_o=1, done_o rises exactly 51 cycles after the write; a second stop store during DRAIN does not extend it.
- StopOnTrap=0, three stores to addr 8 -> trap_cnt_o=3, trap_o=1, stop_o=0, done_o=0.
- Reset pulse at drain cycle 20 -> all outputs 0 immediately; a new stop store restarts the full 51-cycle drain.
- INJECT_EN defined, base=16, len=4 -> read word 19 gives rdata_t0=32'hFFFFFFFF; read word 20 gives the stored taint (0).

Source files
------------

// File: rtl/taint_mem_responder.sv
// taint_mem_responder: data-memory responder for the taint-instrumented SoC.
// Serves reads and writes from a value array plus a byte-parallel taint shadow,
// detects stop/trap signal stores and counts down a drain window before done_o.
// Optional feature macro: TAINT_MEM_RESPONDER_INJECT_EN adds inj_base_i/inj_len_i,
// which force full read-data taint for reads inside [base, base+len).
//
// Handshake: req_i is a valid with no ready; every request is accepted in the
// cycle it is presented (full throughput). A read answers with rdata_o /
// rdata_t0_o and a single-cycle rvalid_o pulse exactly one cycle later; the
// read data holds until the next read. Writes produce no response.
module taint_mem_responder #(
  parameter int unsigned  Depth       = 1 << 15,
  parameter int unsigned  StopAddr    = 0,
  parameter int unsigned  TrapAddr    = 8,
  parameter int unsigned  DrainCycles = 50,
  parameter bit           StopOnTrap  = 1'b1,
  localparam int unsigned Aw          = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
`ifdef TAINT_MEM_RESPONDER_INJECT_EN
  input  logic [Aw-1:0] inj_base_i,
  input  logic [Aw-1:0] inj_len_i,
`endif
  input  logic          req_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    strb_i,
  input  logic          req_t0_i,
  input  logic          we_t0_i,
  input  logic [Aw-1:0] addr_t0_i,
  input  logic [31:0]   wdata_t0_i,
  input  logic [3:0]    strb_t0_i,
  output logic [31:0]   rdata_o,
  output logic [31:0]   rdata_t0_o,
  output logic          rvalid_o,
  output logic          stop_o,
  output logic          trap_o,
  output logic [15:0]   trap_cnt_o,
  output logic          stop_data_tainted_o,
  output logic          taddr_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned     CntW     = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
  localparam logic [CntW-1:0] CntInit  = CntW'(DrainCycles);
  localparam logic [Aw-1:0]   StopWord = Aw'(StopAddr);
  localparam logic [Aw-1:0]   TrapWord = Aw'(TrapAddr);

  // Value and taint arrays; intentionally not reset (environment preloads them).
  logic [31:0] mem  [Depth];
  logic [31:0] tmem [Depth];

  // Raw array read registers (no reset so the arrays map onto block RAM).
  logic [31:0] rd_val_q;
  logic [31:0] rd_tnt_q;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           stop_q, stop_d;
  logic           sdt_q, sdt_d;
  logic           trap_q, trap_d;
  logic [15:0]    trap_cnt_q, trap_cnt_d;
  logic           done_q, done_d;
  logic           taddr_q, taddr_d;
  logic           rvalid_q, rvalid_d;
  logic           rd_any_q, rd_any_d;
  logic [31:0]    rd_force_q, rd_force_d;

  logic        wr_req;
  logic        rd_req;
  logic        stop_store;
  logic        trap_store;
  logic        addr_tainted;
  logic [3:0]  byte_taint;
  logic        inj_hit;

  // Request decode and per-byte write-taint contribution from control fields.
  always_comb begin
    wr_req       = req_i & we_i;
    rd_req       = req_i & ~we_i;
    stop_store   = wr_req & (addr_i == StopWord);
    trap_store   = wr_req & (addr_i == TrapWord);
    addr_tainted = |addr_t0_i;
    byte_taint   = '0;
    for (int b = 0; b < 4; b++) begin
      byte_taint[b] = addr_tainted | we_t0_i | strb_t0_i[b];
    end
  end

`ifdef TAINT_MEM_RESPONDER_INJECT_EN
  logic [Aw:0] inj_end;

  // Injection window check in Aw+1 bits so base+len never wraps.
  always_comb begin
    inj_end = {1'b0, inj_base_i} + {1'b0, inj_len_i};
    inj_hit = ({1'b0, addr_i} >= {1'b0, inj_base_i}) && ({1'b0, addr_i} < inj_end);
  end
`else
  // No injection window in this build.
  always_comb inj_hit = 1'b0;
`endif

  // Byte-masked write into value and taint arrays, plus registered array read.
  always_ff @(posedge clk_i) begin
    if (wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) begin
          mem[addr_i][8*b +: 8]  <= wdata_i[8*b +: 8];
          tmem[addr_i][8*b +: 8] <= wdata_t0_i[8*b +: 8] | {8{byte_taint[b]}};
        end
      end
    end
    if (rd_req) begin
      rd_val_q <= mem[addr_i];
      rd_tnt_q <= tmem[addr_i];
    end
  end

  // Next-state logic: read response flags, sticky flags and the stop FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    sdt_d      = sdt_q;
    done_d     = done_q;
    trap_d     = trap_q | trap_store;
    trap_cnt_d = trap_cnt_q;
    taddr_d    = taddr_q | (req_i & addr_tainted);
    rvalid_d   = rd_req;
    rd_any_d   = rd_any_q | rd_req;
    rd_force_d = rd_force_q;

    if (rd_req) begin
      rd_force_d = {32{addr_tainted | req_t0_i | inj_hit}};
    end

    if (trap_store && (trap_cnt_q != 16'hFFFF)) begin
      trap_cnt_d = trap_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (stop_store || (StopOnTrap && trap_store)) begin
          state_d = StDrain;
          cnt_d   = CntInit;
          stop_d  = 1'b1;
          sdt_d   = |wdata_t0_i;
        end
      end
      StDrain: begin
        // Later stop stores are ignored here: the drain is never re-armed.
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register for FSM, counters and all resettable outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      sdt_q      <= 1'b0;
      trap_q     <= 1'b0;
      trap_cnt_q <= '0;
      done_q     <= 1'b0;
      taddr_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_any_q   <= 1'b0;
      rd_force_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      sdt_q      <= sdt_d;
      trap_q     <= trap_d;
      trap_cnt_q <= trap_cnt_d;
      done_q     <= done_d;
      taddr_q    <= taddr_d;
      rvalid_q   <= rvalid_d;
      rd_any_q   <= rd_any_d;
      rd_force_q <= rd_force_d;
    end
  end

  // Read data reads as zero until the first read after reset, then holds.
  assign rdata_o             = rd_any_q ? rd_val_q : '0;
  assign rdata_t0_o          = rd_any_q ? (rd_tnt_q | rd_force_q) : '0;
  assign rvalid_o            = rvalid_q;
  assign stop_o              = stop_q;
  assign trap_o              = trap_q;
  assign trap_cnt_o          = trap_cnt_q;
  assign stop_data_tainted_o = sdt_q;
  assign taddr_o             = taddr_q;
  assign done_o              = done_q;

endmodule

// File: tb/tb_taint_mem_responder.sv
// tb_taint_mem_responder: three responder instances share one request stream
// (default, StopOnTrap=0, DrainCycles=0) and are checked every cycle against a
// behavioural model: plain word arrays, a stop timestamp per instance and an
// expected-read queue.
`timescale 1ns/1ps
module tb_taint_mem_responder;
  localparam int Aw    = 15;
  localparam int NInst = 3;
  localparam int Words = 64;

  function automatic int dc_of(input int i);
    return (i == 2) ? 0 : 50;
  endfunction

  function automatic bit sot_of(input int i);
    return (i != 1);
  endfunction

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk_i;
  logic          rst_ni;
  logic          req_i, we_i, req_t0_i, we_t0_i;
  logic [Aw-1:0] addr_i, addr_t0_i;
  logic [31:0]   wdata_i, wdata_t0_i;
  logic [3:0]    strb_i, strb_t0_i;
  logic [Aw-1:0] inj_base, inj_len;

  logic [31:0] rdata_w    [NInst];
  logic [31:0] rdata_t0_w [NInst];
  logic        rvalid_w   [NInst];
  logic        stop_w     [NInst];
  logic        trap_w     [NInst];
  logic [15:0] tcnt_w     [NInst];
  logic        sdt_w      [NInst];
  logic        taddr_w    [NInst];
  logic        done_w     [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    taint_mem_responder #(
      .DrainCycles(dc_of(g)),
      .StopOnTrap (sot_of(g))
    ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
`ifdef TAINT_MEM_RESPONDER_INJECT_EN
      .inj_base_i         (inj_base),
      .inj_len_i          (inj_len),
`endif
      .req_i              (req_i),
      .we_i               (we_i),
      .addr_i             (addr_i),
      .wdata_i            (wdata_i),
      .strb_i             (strb_i),
      .req_t0_i           (req_t0_i),
      .we_t0_i            (we_t0_i),
      .addr_t0_i          (addr_t0_i),
      .wdata_t0_i         (wdata_t0_i),
      .strb_t0_i          (strb_t0_i),
      .rdata_o            (rdata_w[g]),
      .rdata_t0_o         (rdata_t0_w[g]),
      .rvalid_o           (rvalid_w[g]),
      .stop_o             (stop_w[g]),
      .trap_o             (trap_w[g]),
      .trap_cnt_o         (tcnt_w[g]),
      .stop_data_tainted_o(sdt_w[g]),
      .taddr_o            (taddr_w[g]),
      .done_o             (done_w[g])
    );
  end

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_val [Words];
  logic [31:0] m_tnt [Words];
  bit          m_stop [NInst];
  bit          m_trap [NInst];
  bit          m_sdt  [NInst];
  bit          m_done [NInst];
  logic [15:0] m_tcnt [NInst];
  int          m_stop_cyc [NInst];
  bit          m_taddr;
  bit          m_rvalid;
  int          cyc;
  logic [63:0] exp_q[$];
  logic [63:0] last_rd;

  task automatic model_clear();
    for (int i = 0; i < NInst; i++) begin
      m_stop[i] = 1'b0; m_trap[i] = 1'b0; m_sdt[i] = 1'b0; m_done[i] = 1'b0;
      m_tcnt[i] = 16'h0; m_stop_cyc[i] = 0;
    end
    m_taddr  = 1'b0;
    m_rvalid = 1'b0;
    exp_q.delete();
    last_rd  = 64'h0;
  endtask

  task automatic model_step();
    int          a;
    logic [31:0] t;
    bit          is_stop, is_trap;
    cyc++;
    m_rvalid = 1'b0;
    if (req_i) begin
      a = int'(addr_i[5:0]);
      if (addr_t0_i != '0) m_taddr = 1'b1;
      if (we_i) begin
        is_stop = (addr_i == Aw'(0));
        is_trap = (addr_i == Aw'(8));
        for (int i = 0; i < NInst; i++) begin
          if (is_trap) begin
            m_trap[i] = 1'b1;
            if (m_tcnt[i] != 16'hFFFF) m_tcnt[i] = m_tcnt[i] + 16'd1;
          end
          if (!m_stop[i] && (is_stop || (is_trap && sot_of(i)))) begin
            m_stop[i]     = 1'b1;
            m_stop_cyc[i] = cyc;
            m_sdt[i]      = (wdata_t0_i != 32'h0);
          end
        end
        for (int b = 0; b < 4; b++) begin
          if (strb_i[b]) begin
            m_val[a][8*b +: 8] = wdata_i[8*b +: 8];
            m_tnt[a][8*b +: 8] = wdata_t0_i[8*b +: 8] |
              (((addr_t0_i != '0) || we_t0_i || strb_t0_i[b]) ? 8'hFF : 8'h00);
          end
        end
      end else begin
        m_rvalid = 1'b1;
        t = m_tnt[a];
        if ((addr_t0_i != '0) || req_t0_i) t = 32'hFFFF_FFFF;
`ifdef TAINT_MEM_RESPONDER_INJECT_EN
        if (int'(inj_len) != 0 && int'(addr_i) >= int'(inj_base) &&
            int'(addr_i) < int'(inj_base) + int'(inj_len)) t = 32'hFFFF_FFFF;
`endif
        exp_q.push_back({t, m_val[a]});
      end
    end
    for (int i = 0; i < NInst; i++) begin
      m_done[i] = m_stop[i] && ((cyc - m_stop_cyc[i]) >= dc_of(i) + 1);
    end
  endtask

  initial begin
    cyc = 0;
    model_clear();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_clear();
      else model_step();
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        if (m_rvalid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL exp_q_empty: got empty want entry at %0t", $time);
          end else begin
            last_rd = exp_q.pop_front();
          end
        end
        for (int i = 0; i < NInst; i++) begin
          chk($sformatf("rvalid[%0d]", i), 64'(rvalid_w[i]), 64'(m_rvalid));
          chk($sformatf("rdata[%0d]", i), 64'(rdata_w[i]), 64'(last_rd[31:0]));
          chk($sformatf("rdata_t0[%0d]", i), 64'(rdata_t0_w[i]), 64'(last_rd[63:32]));
          chk($sformatf("stop[%0d]", i), 64'(stop_w[i]), 64'(m_stop[i]));
          chk($sformatf("trap[%0d]", i), 64'(trap_w[i]), 64'(m_trap[i]));
          chk($sformatf("trap_cnt[%0d]", i), 64'(tcnt_w[i]), 64'(m_tcnt[i]));
          chk($sformatf("stop_data_tainted[%0d]", i), 64'(sdt_w[i]), 64'(m_sdt[i]));
          chk($sformatf("taddr[%0d]", i), 64'(taddr_w[i]), 64'(m_taddr));
          chk($sformatf("done[%0d]", i), 64'(done_w[i]), 64'(m_done[i]));
        end
      end
    end
  end

  // ---------------- driver tasks (all drive at posedge+1) ----------------
  task automatic drive_idle();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; strb_i = '0;
    req_t0_i = 1'b0; we_t0_i = 1'b0; addr_t0_i = '0; wdata_t0_i = '0; strb_t0_i = '0;
  endtask

  task automatic do_write(input logic [Aw-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] dt0, input logic [Aw-1:0] at0,
                          input logic wet0, input logic [3:0] st0);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; strb_i = s;
    req_t0_i = 1'b0; we_t0_i = wet0; addr_t0_i = at0; wdata_t0_i = dt0; strb_t0_i = st0;
    @(posedge clk_i); #1;
    drive_idle();
  endtask

  task automatic do_read(input logic [Aw-1:0] a, input logic [Aw-1:0] at0, input logic rt0);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0; strb_i = '0;
    req_t0_i = rt0; we_t0_i = 1'b0; addr_t0_i = at0; wdata_t0_i = '0; strb_t0_i = '0;
    @(posedge clk_i); #1;
    drive_idle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Counts cycles from an already-accepted stop store until instance 0 raises done.
  task automatic drain_measure(input bit second_stop, output int lat);
    lat = 0;
    while (lat < 200) begin
      if (second_stop && lat == 10) begin
        req_i = 1'b1; we_i = 1'b1; addr_i = '0; wdata_i = 32'h2; strb_i = 4'hF;
      end
      @(posedge clk_i); #1;
      lat++;
      drive_idle();
      if (lat == 1) chk("done_zero_drain", 64'(done_w[2]), 64'd1);
      if (done_w[0]) break;
    end
  endtask

  // ---------------- main sequence ----------------
  int lat;

  initial begin
    rst_ni   = 1'b0;
    inj_base = '0;
    inj_len  = '0;
    drive_idle();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < NInst; i++) begin
      chk($sformatf("reset_done[%0d]", i), 64'(done_w[i]), 64'd0);
      chk($sformatf("reset_trap_cnt[%0d]", i), 64'(tcnt_w[i]), 64'd0);
    end

    // Preload every word of the test window with value 0 and clean taint.
    for (int w = 0; w < Words; w++) do_write(Aw'(w), 32'h0, 4'hF, 32'h0, '0, 1'b0, 4'h0);
    do_reset();

    // Partial-strobe write then read back.
    do_write(Aw'(5), 32'hDEADBEEF, 4'b0101, 32'h0, '0, 1'b0, 4'h0);
    do_read(Aw'(5), '0, 1'b0);
    chk("strb_rdata", 64'(rdata_w[0]), 64'h00AD00EF);
    chk("strb_rdata_t0", 64'(rdata_t0_w[0]), 64'h0);
    chk("strb_rvalid", 64'(rvalid_w[0]), 64'd1);
    @(posedge clk_i); #1;
    chk("rvalid_pulse", 64'(rvalid_w[0]), 64'd0);
    chk("rdata_hold", 64'(rdata_w[0]), 64'h00AD00EF);

    // Write-data taint, then tainted-address read.
    do_write(Aw'(7), 32'h12345678, 4'hF, 32'h000000FF, '0, 1'b0, 4'h0);
    do_read(Aw'(7), Aw'(1), 1'b0);
    chk("taddr_rdata_t0", 64'(rdata_t0_w[0]), 64'hFFFFFFFF);
    chk("taddr_rdata", 64'(rdata_w[0]), 64'h12345678);
    chk("taddr_flag", 64'(taddr_w[0]), 64'd1);
    do_read(Aw'(7), '0, 1'b0);
    chk("stored_taint", 64'(rdata_t0_w[0]), 64'h000000FF);

    // Three trap stores (one with empty strobe).
    do_write(Aw'(8), 32'h1, 4'hF, 32'h0, '0, 1'b0, 4'h0);
    do_write(Aw'(8), 32'h2, 4'h0, 32'h0, '0, 1'b0, 4'h0);
    do_write(Aw'(8), 32'h3, 4'h3, 32'h0, '0, 1'b0, 4'h0);
    chk("trap_cnt_nostop", 64'(tcnt_w[1]), 64'd3);
    chk("trap_flag_nostop", 64'(trap_w[1]), 64'd1);
    chk("stop_nostop", 64'(stop_w[1]), 64'd0);
    chk("done_nostop", 64'(done_w[1]), 64'd0);
    chk("stop_on_trap", 64'(stop_w[0]), 64'd1);

    // Tainted stop store, drain latency with a second stop mid-drain.
    do_reset();
    do_write(Aw'(0), 32'h1, 4'hF, 32'h1, '0, 1'b0, 4'h0);
    chk("stop_next_cycle", 64'(stop_w[0]), 64'd1);
    chk("stop_data_tainted", 64'(sdt_w[0]), 64'd1);
    chk("done_not_yet", 64'(done_w[0]), 64'd0);
    chk("done_zero_not_yet", 64'(done_w[2]), 64'd0);
    drain_measure(1'b1, lat);
    chk("drain_latency", 64'(lat), 64'd51);

    // Reset in the middle of the drain, then a full restart.
    do_reset();
    do_write(Aw'(0), 32'h5, 4'hF, 32'h0, '0, 1'b0, 4'h0);
    repeat (20) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_reset_stop", 64'(stop_w[0]), 64'd0);
    chk("mid_reset_done", 64'(done_w[0]), 64'd0);
    chk("mid_reset_trap", 64'(trap_w[0]), 64'd0);
    chk("mid_reset_rdata", 64'(rdata_w[0]), 64'd0);
    chk("mid_reset_rvalid", 64'(rvalid_w[0]), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    do_write(Aw'(0), 32'h6, 4'hF, 32'h0, '0, 1'b0, 4'h0);
    chk("restart_sdt_clean", 64'(sdt_w[0]), 64'd0);
    drain_measure(1'b0, lat);
    chk("restart_latency", 64'(lat), 64'd51);

`ifdef TAINT_MEM_RESPONDER_INJECT_EN
    inj_base = Aw'(16);
    inj_len  = Aw'(4);
    do_read(Aw'(19), '0, 1'b0);
    chk("inj_inside", 64'(rdata_t0_w[0]), 64'hFFFFFFFF);
    do_read(Aw'(20), '0, 1'b0);
    chk("inj_outside", 64'(rdata_t0_w[0]), 64'h0);
    inj_len = '0;
    do_read(Aw'(19), '0, 1'b0);
    chk("inj_disabled", 64'(rdata_t0_w[0]), 64'h0);
`endif

    // Randomized traffic over the test window, with one reset in the middle.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      req_i      = ($urandom_range(0, 3) != 0);
      we_i       = 1'($urandom_range(0, 1));
      addr_i     = Aw'($urandom_range(0, Words - 1));
      wdata_i    = $urandom;
      strb_i     = 4'($urandom_range(0, 15));
      req_t0_i   = ($urandom_range(0, 15) == 0);
      we_t0_i    = ($urandom_range(0, 15) == 0);
      addr_t0_i  = ($urandom_range(0, 31) == 0) ? Aw'(1) << $urandom_range(0, Aw - 1) : '0;
      wdata_t0_i = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      strb_t0_i  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
`ifdef TAINT_MEM_RESPONDER_INJECT_EN
      inj_base = Aw'($urandom_range(0, Words - 1));
      inj_len  = Aw'($urandom_range(0, 8));
`endif
      @(posedge clk_i); #1;
    end
    drive_idle();
    repeat (60) @(posedge clk_i);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #1_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
